rst_seq_ctrl: RTL and testbench
===============================

Name: rst_seq_ctrl

Overview:
Parametrised multi-channel reset sequencer for the collision-detection datapath. On the rising edge of chip-select it issues an initial active-low reset pulse. Once armed, it issues re-arm reset pulses after a configurable number of done_i events, releasing N_CH downstream reset domains in staggered order. Sits between the JTAG/memory front end and the collision cores, in place of the single-output reset controller.

Parameters:
N_CH, 2, number of reset output channels (>=1)
PRE_CYC, 1, cycles rst_out_n stays high after cs_i rise before asserting (0 allowed)
PULSE_CYC, 1, cycles all channels are held low (>=1)
STAGGER_CYC, 0, cycles between release of channel i and channel i+1
DONE_SKIP, 1, done_i rising edges ignored before the qualifying edge (qualifying edge = edge number DONE_SKIP+1)
REPEAT, 0, 0 = one re-arm pulse per cs_i session; 1 = re-arm on every (DONE_SKIP+1)th edge
HOLDOFF_CYC, 4, cycles after a re-arm sequence during which done_i edges are ignored
CNT_W, 8, width of seq_cnt

Ports:
clk  input  1  system clock
flagRst2  input  1  reset, asynchronous, active-high
cs_i  input  1  chip-select/enable, synchronous to clk
done_i  input  1  collision-done strobe/level, synchronous to clk
rst_out_n  output  N_CH  per-channel reset, active-low (0 = domain held in reset)
busy  output  1  high while a pulse/release sequence is in progress
armed  output  1  high in ARMED state
seq_cnt  output  CNT_W  completed sequences (init + re-arm), saturating at all-ones

Behaviour:
- Reset (flagRst2=1, async): rst_out_n=all ones, busy=0, armed=0, seq_cnt=0, state IDLE, done edge counter=0, prev-sample registers=0.
- All outputs registered. cs_i and done_i edges are detected against registered previous samples.
- States: IDLE, PRE, ASSERT, RELEASE, ARMED, HOLDOFF, DONE_ONE (one-shot complete).
- IDLE: cs rise sampled at edge E -> PRE (or ASSERT if PRE_CYC=0). Simultaneous done rise is ignored.
- Init timing: all rst_out_n fall at edge E+PRE_CYC+1. Channel i rises at edge E+PRE_CYC+1+PULSE_CYC+i*STAGGER_CYC. With STAGGER_CYC=0, all channels rise together.
- busy is high from edge E+1 until the edge where the last channel rises; it drops on that same edge. At that edge seq_cnt increments and the state goes to ARMED.
- ARMED: count done_i rising edges. At the qualifying edge D, reset the edge counter and go to ASSERT. rst_out_n falls at D+1; channel i rises at D+1+PULSE_CYC+i*STAGGER_CYC.
- After a re-arm release: seq_cnt increments. Go to HOLDOFF for HOLDOFF_CYC cycles (done edges ignored, not counted), then to ARMED if REPEAT=1, else to DONE_ONE. If HOLDOFF_CYC=0, go directly to the next state.
- DONE_ONE: all channels high, done_i ignored until cs_i falls.
- cs_i low sampled in any non-IDLE state: abort. Next edge: rst_out_n=all ones, busy=0, armed=0, edge counter=0, state IDLE. seq_cnt is retained.
- cs_i held high continuously never retriggers the init sequence; a fresh rise is required.
- done_i held high counts as one edge.
- seq_cnt saturates; it does not wrap.
- Timer width: $clog2(max(PRE_CYC,PULSE_CYC,STAGGER_CYC,HOLDOFF_CYC)+1). Edge counter width: $clog2(DONE_SKIP+2).
- flagRst2 asserted mid-sequence: immediate return to reset values. Note that the reset value of rst_out_n is all ones, i.e. downstream domains are released.

Decomposition:
- Package rst_seq_pkg: state enum type, TIMER_W/EDGE_W width functions, a static assertion helper for parameter legality (PULSE_CYC>=1, N_CH>=1).
- Sub-module rst_seq_timer: loadable down-counter with load value, enable and zero flag. It is instantiated once and reused for the PRE, PULSE, STAGGER and HOLDOFF phases.
- Per-channel release is a release index counter in the top level; there is no per-channel instance.

Test Plan:
- Defaults, cs_i rise at edge 10 -> rst_out_n=2'b00 at edge 12 and 2'b11 at edge 13; seq_cnt=1; armed=1 at edge 13.
- Defaults, then done_i pulses at edges 20 and 25 -> no action at 20; rst_out_n=00 at 26 and 11 at 27; seq_cnt=2; third done pulse at 40 -> no pulse (one-shot).
- N_CH=4, STAGGER_CYC=2, PULSE_CYC=3, PRE_CYC=0, cs_i rise at edge 5 -> all low at 6; channels 0..3 rise at 9, 11, 13, 15; busy falls at 15.
- REPEAT=1, DONE_SKIP=0, HOLDOFF_CYC=4, done pulses at 30 and 33 -> pulse at 31 only (33 is inside holdoff); done pulse at 40 -> pulse at 41.
- cs_i drops at edge 12 while in ASSERT (init at 10, PULSE_CYC=5) -> rst_out_n=all ones at 13, state IDLE; new cs_i rise at 20 restarts the init sequence.
- flagRst2 pulsed asynchronously mid-RELEASE -> outputs at reset values immediately, seq_cnt=0; simultaneous cs_i and done_i rise in IDLE -> only the init sequence runs.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StAssert,
    StRelease,
    StArmed,
    StHoldoff,
    StDoneOne
  } rst_seq_state_e;

  function automatic int unsigned timer_w(input int unsigned pre, input int unsigned pulse,
                                          input int unsigned stagger, input int unsigned holdoff);
    int unsigned m;
    int unsigned w;
    m = pre;
    if (pulse > m) m = pulse;
    if (stagger > m) m = stagger;
    if (holdoff > m) m = holdoff;
    w = $clog2(m + 1);
    return (w == 0) ? 1 : w;
  endfunction

  function automatic int unsigned edge_w(input int unsigned done_skip);
    return $clog2(done_skip + 2);
  endfunction

  function automatic bit params_legal(input int unsigned n_ch, input int unsigned pulse_cyc);
    return (n_ch >= 1) && (pulse_cyc >= 1);
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable down-counter shared by the PRE, PULSE, STAGGER and HOLDOFF phases.
module rst_seq_timer #(
  parameter int unsigned Width = 3
) (
  input  logic             clk,
  input  logic             flagRst2,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk or posedge flagRst2) begin
    if (flagRst2) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Multi-channel reset sequencer: init pulse on cs_i rise, re-arm pulses on qualifying done_i
// edges, staggered per-channel release.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned PRE_CYC     = 1,
  parameter int unsigned PULSE_CYC   = 1,
  parameter int unsigned STAGGER_CYC = 0,
  parameter int unsigned DONE_SKIP   = 1,
  parameter int unsigned REPEAT      = 0,
  parameter int unsigned HOLDOFF_CYC = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             flagRst2,
  input  logic             cs_i,
  input  logic             done_i,
  output logic [N_CH-1:0]  rst_out_n,
  output logic             busy,
  output logic             armed,
  output logic [CNT_W-1:0] seq_cnt
);

  localparam int unsigned TimerW = timer_w(PRE_CYC, PULSE_CYC, STAGGER_CYC, HOLDOFF_CYC);
  localparam int unsigned EdgeW  = edge_w(DONE_SKIP);
  localparam int unsigned IdxW   = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [TimerW-1:0] PreLoad     = TimerW'((PRE_CYC > 0) ? PRE_CYC - 1 : 0);
  localparam logic [TimerW-1:0] PulseLoad   = TimerW'(PULSE_CYC - 1);
  localparam logic [TimerW-1:0] StaggerLoad = TimerW'((STAGGER_CYC > 0) ? STAGGER_CYC - 1 : 0);
  localparam logic [TimerW-1:0] HoldLoad    = TimerW'((HOLDOFF_CYC > 0) ? HOLDOFF_CYC - 1 : 0);
  localparam logic [EdgeW-1:0]  SkipVal     = EdgeW'(DONE_SKIP);
  localparam logic [IdxW-1:0]   LastIdx     = IdxW'(N_CH - 1);

  if (!params_legal(N_CH, PULSE_CYC)) begin : g_bad_params
    $error("rst_seq_ctrl: N_CH and PULSE_CYC must both be >= 1");
  end

  rst_seq_state_e    state_q;
  logic              cs_prev_q, done_prev_q, rearm_q;
  logic [EdgeW-1:0]  edge_cnt_q;
  logic [IdxW-1:0]   rel_idx_q;
  logic              t_load, t_zero;
  logic [TimerW-1:0] t_val;
  logic              cs_rise, done_rise, last_rel;

  assign cs_rise   = cs_i & ~cs_prev_q;
  assign done_rise = done_i & ~done_prev_q;
  // Zero stagger releases every channel on the same edge.
  assign last_rel  = (STAGGER_CYC == 0) || (rel_idx_q == LastIdx);

  rst_seq_timer #(
    .Width (TimerW)
  ) u_timer (
    .clk        (clk),
    .flagRst2   (flagRst2),
    .load_i     (t_load),
    .load_val_i (t_val),
    .en_i       (1'b1),
    .zero_o     (t_zero)
  );

  always_comb begin
    t_load = 1'b0;
    t_val  = '0;
    case (state_q)
      StIdle: begin
        if (cs_rise) begin
          t_load = 1'b1;
          t_val  = PreLoad;
        end
      end
      StAssert: begin
        t_load = 1'b1;
        t_val  = PulseLoad;
      end
      StRelease: begin
        if (t_zero) begin
          t_load = 1'b1;
          t_val  = last_rel ? HoldLoad : StaggerLoad;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge flagRst2) begin
    if (flagRst2) begin
      state_q     <= StIdle;
      cs_prev_q   <= 1'b0;
      done_prev_q <= 1'b0;
      rearm_q     <= 1'b0;
      edge_cnt_q  <= '0;
      rel_idx_q   <= '0;
      rst_out_n   <= '1;
      busy        <= 1'b0;
      armed       <= 1'b0;
      seq_cnt     <= '0;
    end else begin
      cs_prev_q   <= cs_i;
      done_prev_q <= done_i;
      // Abort: go idle now; IDLE restores the output values on the following edge.
      if ((state_q != StIdle) && !cs_i) begin
        state_q    <= StIdle;
        edge_cnt_q <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            rst_out_n  <= '1;
            busy       <= 1'b0;
            armed      <= 1'b0;
            edge_cnt_q <= '0;
            if (cs_rise) begin
              rearm_q <= 1'b0;
              state_q <= (PRE_CYC == 0) ? StAssert : StPre;
            end
          end
          StPre: begin
            busy <= 1'b1;
            if (t_zero) state_q <= StAssert;
          end
          StAssert: begin
            busy      <= 1'b1;
            rst_out_n <= '0;
            rel_idx_q <= '0;
            state_q   <= StRelease;
          end
          StRelease: begin
            if (t_zero) begin
              if (STAGGER_CYC == 0) rst_out_n <= '1;
              else rst_out_n[rel_idx_q] <= 1'b1;
              if (last_rel) begin
                busy <= 1'b0;
                if (seq_cnt != '1) seq_cnt <= seq_cnt + 1'b1;
                if (!rearm_q || ((HOLDOFF_CYC == 0) && (REPEAT != 0))) begin
                  state_q <= StArmed;
                  armed   <= 1'b1;
                end else if (HOLDOFF_CYC == 0) begin
                  state_q <= StDoneOne;
                end else begin
                  state_q <= StHoldoff;
                end
              end else begin
                rel_idx_q <= rel_idx_q + 1'b1;
              end
            end
          end
          StArmed: begin
            if (done_rise) begin
              if (edge_cnt_q == SkipVal) begin
                edge_cnt_q <= '0;
                rearm_q    <= 1'b1;
                armed      <= 1'b0;
                state_q    <= StAssert;
              end else begin
                edge_cnt_q <= edge_cnt_q + 1'b1;
              end
            end
          end
          StHoldoff: begin
            if (t_zero) begin
              if (REPEAT != 0) begin
                state_q <= StArmed;
                armed   <= 1'b1;
              end else begin
                state_q <= StDoneOne;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl across four parameter sets sharing clock and stimulus.
module tb_rst_seq_ctrl;

  logic clk = 1'b0;
  logic flag_rst = 1'b1;
  logic cs = 1'b0;
  logic done = 1'b0;

  logic [1:0] def_rst, rep_rst, abt_rst;
  logic [3:0] stg_rst;
  logic       def_busy, stg_busy, rep_busy, abt_busy;
  logic       def_armed, stg_armed, rep_armed, abt_armed;
  logic [7:0] def_cnt, stg_cnt, rep_cnt, abt_cnt;

  int n = 0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rst_seq_ctrl u_def (
    .clk(clk), .flagRst2(flag_rst), .cs_i(cs), .done_i(done),
    .rst_out_n(def_rst), .busy(def_busy), .armed(def_armed), .seq_cnt(def_cnt)
  );

  rst_seq_ctrl #(
    .N_CH(4), .PRE_CYC(0), .PULSE_CYC(3), .STAGGER_CYC(2)
  ) u_stg (
    .clk(clk), .flagRst2(flag_rst), .cs_i(cs), .done_i(done),
    .rst_out_n(stg_rst), .busy(stg_busy), .armed(stg_armed), .seq_cnt(stg_cnt)
  );

  rst_seq_ctrl #(
    .REPEAT(1), .DONE_SKIP(0), .HOLDOFF_CYC(4)
  ) u_rep (
    .clk(clk), .flagRst2(flag_rst), .cs_i(cs), .done_i(done),
    .rst_out_n(rep_rst), .busy(rep_busy), .armed(rep_armed), .seq_cnt(rep_cnt)
  );

  rst_seq_ctrl #(
    .PULSE_CYC(5)
  ) u_abt (
    .clk(clk), .flagRst2(flag_rst), .cs_i(cs), .done_i(done),
    .rst_out_n(abt_rst), .busy(abt_busy), .armed(abt_armed), .seq_cnt(abt_cnt)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  // After step(), outputs reflect edge n and new inputs are sampled at edge n+1.
  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic run_to(input int e);
    while (n < e) step();
  endtask

  task automatic do_reset();
    cs       = 1'b0;
    done     = 1'b0;
    flag_rst = 1'b1;
    step();
    step();
    flag_rst = 1'b0;
    n = 0;
  endtask

  logic [3:0] stg_exp [10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001,
                               4'b0011, 4'b0011, 4'b0111, 4'b0111, 4'b1111};

  initial begin
    // Reset values
    do_reset();
    check_eq("rst_rst_out_n", {6'd0, def_rst}, 8'h03);
    check_eq("rst_busy", {7'd0, def_busy}, 8'h00);
    check_eq("rst_armed", {7'd0, def_armed}, 8'h00);
    check_eq("rst_seq_cnt", def_cnt, 8'h00);

    // Defaults: init on cs rise at edge 10, then one-shot re-arm
    run_to(9);  cs = 1'b1;
    run_to(10); check_eq("init_busy_e10", {7'd0, def_busy}, 8'h00);
    run_to(11); check_eq("init_busy_e11", {7'd0, def_busy}, 8'h01);
                check_eq("init_rst_e11", {6'd0, def_rst}, 8'h03);
    run_to(12); check_eq("init_rst_e12", {6'd0, def_rst}, 8'h00);
    run_to(13); check_eq("init_rst_e13", {6'd0, def_rst}, 8'h03);
                check_eq("init_busy_e13", {7'd0, def_busy}, 8'h00);
                check_eq("init_armed_e13", {7'd0, def_armed}, 8'h01);
                check_eq("init_cnt_e13", def_cnt, 8'h01);
    run_to(19); done = 1'b1;
    run_to(20); done = 1'b0;
    run_to(21); check_eq("skip_rst_e21", {6'd0, def_rst}, 8'h03);
                check_eq("skip_armed_e21", {7'd0, def_armed}, 8'h01);
    run_to(24); done = 1'b1;
    run_to(25); done = 1'b0;
                check_eq("rearm_armed_e25", {7'd0, def_armed}, 8'h00);
    run_to(26); check_eq("rearm_rst_e26", {6'd0, def_rst}, 8'h00);
                check_eq("rearm_busy_e26", {7'd0, def_busy}, 8'h01);
    run_to(27); check_eq("rearm_rst_e27", {6'd0, def_rst}, 8'h03);
                check_eq("rearm_cnt_e27", def_cnt, 8'h02);
    run_to(39); done = 1'b1;
    run_to(40); done = 1'b0;
    run_to(41); check_eq("oneshot_rst_e41", {6'd0, def_rst}, 8'h03);
    run_to(42); check_eq("oneshot_rst_e42", {6'd0, def_rst}, 8'h03);
                check_eq("oneshot_cnt_e42", def_cnt, 8'h02);
                check_eq("oneshot_busy_e42", {7'd0, def_busy}, 8'h00);
    run_to(44); cs = 1'b0;
    run_to(46); check_eq("csdrop_cnt_kept", def_cnt, 8'h02);
                check_eq("csdrop_armed", {7'd0, def_armed}, 8'h00);

    // Staggered release: N_CH=4, PRE_CYC=0, PULSE_CYC=3, STAGGER_CYC=2
    do_reset();
    run_to(4); cs = 1'b1;
    for (int e = 6; e <= 15; e++) begin
      run_to(e);
      check_eq($sformatf("stg_rst_e%0d", e), {4'd0, stg_rst}, {4'd0, stg_exp[e-6]});
      if (e == 14) check_eq("stg_busy_e14", {7'd0, stg_busy}, 8'h01);
    end
    check_eq("stg_busy_e15", {7'd0, stg_busy}, 8'h00);
    check_eq("stg_cnt_e15", stg_cnt, 8'h01);

    // REPEAT=1, DONE_SKIP=0, HOLDOFF_CYC=4
    do_reset();
    run_to(9);  cs = 1'b1;
    run_to(13); check_eq("rep_armed_e13", {7'd0, rep_armed}, 8'h01);
    run_to(29); done = 1'b1;
    run_to(30); done = 1'b0;
    run_to(31); check_eq("rep_rst_e31", {6'd0, rep_rst}, 8'h00);
    run_to(32); check_eq("rep_rst_e32", {6'd0, rep_rst}, 8'h03);
                check_eq("rep_cnt_e32", rep_cnt, 8'h02);
                done = 1'b1;
    run_to(33); done = 1'b0;
    run_to(34); check_eq("rep_hold_rst_e34", {6'd0, rep_rst}, 8'h03);
                check_eq("rep_hold_busy_e34", {7'd0, rep_busy}, 8'h00);
    run_to(35); check_eq("rep_hold_armed_e35", {7'd0, rep_armed}, 8'h00);
    run_to(37); check_eq("rep_armed_e37", {7'd0, rep_armed}, 8'h01);
    run_to(39); done = 1'b1;
    run_to(40); done = 1'b0;
    run_to(41); check_eq("rep_rst_e41", {6'd0, rep_rst}, 8'h00);
    run_to(42); check_eq("rep_rst_e42", {6'd0, rep_rst}, 8'h03);
                check_eq("rep_cnt_e42", rep_cnt, 8'h03);

    // Abort during ASSERT with PULSE_CYC=5, then restart
    do_reset();
    run_to(9);  cs = 1'b1;
    run_to(11); cs = 1'b0;
    run_to(13); check_eq("abt_rst_e13", {6'd0, abt_rst}, 8'h03);
                check_eq("abt_busy_e13", {7'd0, abt_busy}, 8'h00);
                check_eq("abt_armed_e13", {7'd0, abt_armed}, 8'h00);
    run_to(19); cs = 1'b1;
    run_to(21); check_eq("abt_busy_e21", {7'd0, abt_busy}, 8'h01);
    run_to(22); check_eq("abt_rst_e22", {6'd0, abt_rst}, 8'h00);
    run_to(26); check_eq("abt_rst_e26", {6'd0, abt_rst}, 8'h00);
    run_to(27); check_eq("abt_rst_e27", {6'd0, abt_rst}, 8'h03);
                check_eq("abt_cnt_e27", abt_cnt, 8'h01);
                check_eq("abt_armed_e27", {7'd0, abt_armed}, 8'h01);

    // Simultaneous cs/done rise in IDLE, then async reset mid-RELEASE
    do_reset();
    run_to(4);  cs = 1'b1; done = 1'b1;
    run_to(5);  done = 1'b0;
    run_to(7);  check_eq("sim_rst_e7", {6'd0, def_rst}, 8'h00);
    run_to(8);  check_eq("sim_rst_e8", {6'd0, def_rst}, 8'h03);
                check_eq("sim_cnt_e8", def_cnt, 8'h01);
    run_to(11); done = 1'b1;
    run_to(12); done = 1'b0;
    run_to(13); check_eq("sim_rst_e13", {6'd0, def_rst}, 8'h03);
    run_to(14); done = 1'b1;
    run_to(15); done = 1'b0;
    run_to(16); check_eq("sim_rst_e16", {6'd0, def_rst}, 8'h00);
                check_eq("sim_busy_e16", {7'd0, def_busy}, 8'h01);
    flag_rst = 1'b1;
    #2;
    check_eq("arst_rst", {6'd0, def_rst}, 8'h03);
    check_eq("arst_busy", {7'd0, def_busy}, 8'h00);
    check_eq("arst_armed", {7'd0, def_armed}, 8'h00);
    check_eq("arst_cnt", def_cnt, 8'h00);
    flag_rst = 1'b0;
    cs = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
